// File: rtl/fbs_pkg.sv
// Shared types, default widths and sizing helpers for the feedback suppressor controller.
package fbs_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MONITOR = 2'd1,
        ST_CFG     = 2'd2,
        ST_HOLD    = 2'd3
    } fbs_state_e;

    localparam int FBS_DATA_W    = 8;
    localparam int FBS_WIN_LEN   = 256;
    localparam int FBS_DET_COUNT = 3;
    localparam int FBS_HOLD_WIN  = 16;

    // Bits needed for a counter that runs 0..n-1 (at least one bit).
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int FBS_ACC_W  = FBS_DATA_W + $clog2(FBS_WIN_LEN);
    localparam int FBS_HOT_W  = cnt_w(FBS_DET_COUNT);
    localparam int FBS_HOLD_W = cnt_w(FBS_HOLD_WIN);

endpackage

// File: rtl/feedback_suppressor_ctrl_if.sv
// Attenuation config port towards the suppressor datapath (valid/ready, write on valid & ready).
interface feedback_suppressor_ctrl_if #(
    parameter int DATA_W = 8
) ();
    logic              o_cfg_valid;
    logic [DATA_W-1:0] o_cfg_data;
    logic              i_cfg_ready;

    modport master (output o_cfg_valid, output o_cfg_data, input i_cfg_ready);
    modport slave  (input o_cfg_valid, input o_cfg_data, output i_cfg_ready);
endinterface

// File: rtl/fbs_level_meter.sv
// Sample strobe divider plus windowed sum of |sample|; win_end/loud are combinational on the last strobe.
// Free-running divider; accumulator and sample counter are held at zero while run is low.
module fbs_level_meter
    import fbs_pkg::*;
#(
    parameter int DATA_W     = FBS_DATA_W,
    parameter int CLK_DIV    = 1000,
    parameter int WIN_LEN    = FBS_WIN_LEN,
    parameter int DET_THRESH = 16384
) (
    input  logic                     i_clk,
    input  logic                     i_reset_n,
    input  logic                     run,
    input  logic signed [DATA_W-1:0] i_data,
    output logic                     stb,
    output logic                     win_end,
    output logic                     loud
);

    localparam int DIV_W = cnt_w(CLK_DIV);
    localparam int SMP_W = cnt_w(WIN_LEN);
    localparam int ACC_W = DATA_W + $clog2(WIN_LEN);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'(WIN_LEN - 1);

    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic [SMP_W-1:0]  smp_cnt_q, smp_cnt_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [DATA_W-1:0] mag;
    logic [ACC_W-1:0]  sum;

    // Unsigned magnitude: the most negative code maps to 2^(DATA_W-1), which still fits.
    assign mag = i_data[DATA_W-1] ? DATA_W'(-i_data) : DATA_W'(i_data);
    assign sum = acc_q + ACC_W'(mag);
    assign stb = (div_cnt_q == DIV_LAST);

    always_comb begin
        div_cnt_d = stb ? '0 : div_cnt_q + 1'b1;
        acc_d     = acc_q;
        smp_cnt_d = smp_cnt_q;
        win_end   = 1'b0;
        loud      = 1'b0;
        if (!run) begin
            acc_d     = '0;
            smp_cnt_d = '0;
        end else if (stb) begin
            if (smp_cnt_q == SMP_LAST) begin
                win_end   = 1'b1;
                loud      = (64'(sum) >= 64'(DET_THRESH));
                acc_d     = '0;
                smp_cnt_d = '0;
            end else begin
                acc_d     = sum;
                smp_cnt_d = smp_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            div_cnt_q <= '0;
            smp_cnt_q <= '0;
            acc_q     <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
            smp_cnt_q <= smp_cnt_d;
            acc_q     <= acc_d;
        end
    end

endmodule

// File: rtl/feedback_suppressor_ctrl.sv
// Howl detection sequencer: engages, holds and releases attenuation through a valid/ready config write.
// Config data is held stable until accepted; window ends seen while a write is pending are dropped.
module feedback_suppressor_ctrl
    import fbs_pkg::*;
#(
    parameter int DATA_W     = FBS_DATA_W,
    parameter int CLK_DIV    = 1000,
    parameter int WIN_LEN    = FBS_WIN_LEN,
    parameter int DET_THRESH = 16384,
    parameter int DET_COUNT  = FBS_DET_COUNT,
    parameter int HOLD_WIN   = FBS_HOLD_WIN,
    parameter int ATT_STEP   = 4,
    parameter int MAX_ATT    = 12
) (
    input  logic                       i_clk,
    input  logic                       i_reset_n,
    input  logic                       i_enable,
    input  logic signed [DATA_W-1:0]   i_data,
    output logic                       o_sample_stb,
    feedback_suppressor_ctrl_if.master cfg,
    output logic                       o_active,
    output logic [1:0]                 o_state
);

    localparam int HOT_W  = cnt_w(DET_COUNT);
    localparam int HOLD_W = cnt_w(HOLD_WIN);

    localparam logic [HOT_W-1:0]  HOT_LAST  = HOT_W'(DET_COUNT - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_WIN - 1);
    localparam logic [DATA_W-1:0] MAX_A     = DATA_W'(MAX_ATT);
    localparam logic [DATA_W-1:0] STEP_A    = DATA_W'(ATT_STEP);

    fbs_state_e        state_q, state_d;
    logic [DATA_W-1:0] att_q, att_d;
    logic [HOT_W-1:0]  hot_cnt_q, hot_cnt_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              disabling_q, disabling_d;
    logic              dis_pend_q, dis_pend_d;
    logic              active_q, active_d;

    logic              win_end;
    logic              loud;
    logic [DATA_W:0]   att_up_w;
    logic [DATA_W-1:0] att_up;
    logic [DATA_W-1:0] att_dn;

    fbs_level_meter #(
        .DATA_W     (DATA_W),
        .CLK_DIV    (CLK_DIV),
        .WIN_LEN    (WIN_LEN),
        .DET_THRESH (DET_THRESH)
    ) u_meter (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .run       (state_q != ST_IDLE),
        .i_data    (i_data),
        .stb       (o_sample_stb),
        .win_end   (win_end),
        .loud      (loud)
    );

    assign att_up_w = {1'b0, att_q} + {1'b0, STEP_A};
    assign att_up   = (att_up_w > {1'b0, MAX_A}) ? MAX_A : att_up_w[DATA_W-1:0];
    assign att_dn   = (att_q > STEP_A) ? (att_q - STEP_A) : '0;

    always_comb begin
        state_d     = state_q;
        att_d       = att_q;
        hot_cnt_d   = hot_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        disabling_d = disabling_q;
        dis_pend_d  = dis_pend_q;
        case (state_q)
            ST_IDLE: begin
                hot_cnt_d   = '0;
                hold_cnt_d  = '0;
                disabling_d = 1'b0;
                dis_pend_d  = 1'b0;
                if (i_enable) state_d = ST_MONITOR;
            end
            ST_MONITOR: begin
                if (!i_enable || dis_pend_q) begin
                    dis_pend_d = 1'b0;
                    hot_cnt_d  = '0;
                    if (att_q != '0) begin
                        att_d       = '0;
                        disabling_d = 1'b1;
                        state_d     = ST_CFG;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (win_end) begin
                    if (!loud) begin
                        hot_cnt_d = '0;
                    end else if (hot_cnt_q == HOT_LAST) begin
                        att_d     = att_up;
                        hot_cnt_d = '0;
                        state_d   = ST_CFG;
                    end else begin
                        hot_cnt_d = hot_cnt_q + 1'b1;
                    end
                end
            end
            ST_CFG: begin
                // A disable seen mid-handshake is remembered and turned into a zero write afterwards.
                if (!i_enable) dis_pend_d = 1'b1;
                if (cfg.i_cfg_ready) begin
                    hot_cnt_d  = '0;
                    hold_cnt_d = '0;
                    if (disabling_q) begin
                        disabling_d = 1'b0;
                        dis_pend_d  = 1'b0;
                        state_d     = ST_IDLE;
                    end else begin
                        state_d = (att_q == '0) ? ST_MONITOR : ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (!i_enable || dis_pend_q) begin
                    dis_pend_d = 1'b0;
                    hold_cnt_d = '0;
                    if (att_q != '0) begin
                        att_d       = '0;
                        disabling_d = 1'b1;
                        state_d     = ST_CFG;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (win_end) begin
                    if (loud) begin
                        hold_cnt_d = '0;
                        if (att_q < MAX_A) begin
                            att_d   = att_up;
                            state_d = ST_CFG;
                        end
                    end else if (hold_cnt_q == HOLD_LAST) begin
                        hold_cnt_d = '0;
                        att_d      = att_dn;
                        state_d    = ST_CFG;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        active_d = (att_d != '0);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q     <= ST_IDLE;
            att_q       <= '0;
            hot_cnt_q   <= '0;
            hold_cnt_q  <= '0;
            disabling_q <= 1'b0;
            dis_pend_q  <= 1'b0;
            active_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            att_q       <= att_d;
            hot_cnt_q   <= hot_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            disabling_q <= disabling_d;
            dis_pend_q  <= dis_pend_d;
            active_q    <= active_d;
        end
    end

    // Valid comes straight from the state flop so an async reset kills it immediately.
    assign cfg.o_cfg_valid = (state_q == ST_CFG);
    assign cfg.o_cfg_data  = att_q;
    assign o_active        = active_q;
    assign o_state         = state_q;

endmodule

// File: tb/tb_feedback_suppressor_ctrl.sv
// Scoreboarded bench: expected config writes are queued as stimulus is applied and popped on each handshake.
module tb_feedback_suppressor_ctrl;

    logic              clk;
    logic              rst_n;
    logic              enable;
    logic signed [7:0] data;
    logic              stb;
    logic              active;
    logic [1:0]        state;

    int checks = 0;
    int errors = 0;
    int writes = 0;
    logic [7:0] exp_q[$];

    feedback_suppressor_ctrl_if #(.DATA_W(8)) cfg_if ();

    feedback_suppressor_ctrl #(
        .DATA_W     (8),
        .CLK_DIV    (4),
        .WIN_LEN    (4),
        .DET_THRESH (200),
        .DET_COUNT  (2),
        .HOLD_WIN   (3),
        .ATT_STEP   (4),
        .MAX_ATT    (12)
    ) dut (
        .i_clk        (clk),
        .i_reset_n    (rst_n),
        .i_enable     (enable),
        .i_data       (data),
        .o_sample_stb (stb),
        .cfg          (cfg_if),
        .o_active     (active),
        .o_state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Handshake monitor samples one time unit before the rising edge that completes the write.
    always @(negedge clk) begin
        #4;
        if (rst_n && cfg_if.o_cfg_valid && cfg_if.i_cfg_ready) begin
            writes++;
            if (exp_q.size() == 0) chk("wr_unexpected", cfg_if.o_cfg_data, 32'hdead);
            else chk("wr_data", cfg_if.o_cfg_data, exp_q.pop_front());
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_state(input logic [1:0] s, input int budget);
        int n = 0;
        while (state !== s && n < budget) begin
            step();
            n++;
        end
        chk("wait_state", state, s);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        chk("sb_drain", exp_q.size(), 0);
    endtask

    initial begin
        rst_n  = 1'b0;
        enable = 1'b0;
        data   = 8'sd0;
        cfg_if.i_cfg_ready = 1'b1;
        step();
        step();
        chk("rst_state", state, 0);
        chk("rst_valid", cfg_if.o_cfg_valid, 0);
        chk("rst_active", active, 0);
        chk("rst_stb", stb, 0);

        // Strobe cadence while disabled: count 0 is visible right after release.
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 24; i++) begin
            chk("stb", stb, (i % 4 == 3) ? 1 : 0);
            chk("idle_state", state, 0);
            chk("idle_valid", cfg_if.o_cfg_valid, 0);
            chk("idle_active", active, 0);
            step();
        end

        // Engage on two loud windows of 4 x 100.
        enable = 1'b1;
        data   = 8'sd100;
        exp_q.push_back(8'd4);
        step();
        chk("en_monitor", state, 1);
        wait_state(2'd2, 200);
        chk("eng_data", cfg_if.o_cfg_data, 4);
        step();
        chk("eng_hold", state, 3);
        chk("eng_active", active, 1);
        chk("eng_valid_drop", cfg_if.o_cfg_valid, 0);

        // Continued howl steps up to the ceiling, then stays quiet on the config port.
        exp_q.push_back(8'd8);
        exp_q.push_back(8'd12);
        wait_drain(200);
        for (int i = 0; i < 48; i++) step();
        chk("max_hold", state, 3);
        chk("max_writes", writes, 3);

        // Release: three quiet windows per step down to zero.
        data = 8'sd0;
        exp_q.push_back(8'd8);
        exp_q.push_back(8'd4);
        exp_q.push_back(8'd0);
        wait_drain(600);
        step();
        chk("rel_monitor", state, 1);
        chk("rel_active", active, 0);

        // Re-engage on most negative samples with a stalled datapath.
        cfg_if.i_cfg_ready = 1'b0;
        data = -8'sd128;
        exp_q.push_back(8'd4);
        wait_state(2'd2, 200);
        for (int i = 0; i < 10; i++) begin
            chk("stall_valid", cfg_if.o_cfg_valid, 1);
            chk("stall_data", cfg_if.o_cfg_data, 4);
            step();
        end
        cfg_if.i_cfg_ready = 1'b1;
        wait_drain(20);
        step();
        chk("neg_hold", state, 3);
        chk("neg_active", active, 1);

        // Disable during a stalled write of 8: it completes, then zero is written.
        cfg_if.i_cfg_ready = 1'b0;
        exp_q.push_back(8'd8);
        wait_state(2'd2, 200);
        chk("dis_data", cfg_if.o_cfg_data, 8);
        enable = 1'b0;
        exp_q.push_back(8'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("dis_valid", cfg_if.o_cfg_valid, 1);
            chk("dis_hold_data", cfg_if.o_cfg_data, 8);
        end
        cfg_if.i_cfg_ready = 1'b1;
        wait_drain(20);
        wait_state(2'd0, 20);
        chk("dis_active", active, 0);

        // Reset mid-handshake drops valid without waiting for a clock edge.
        cfg_if.i_cfg_ready = 1'b0;
        enable = 1'b1;
        data   = 8'sd100;
        wait_state(2'd2, 200);
        chk("pre_rst_valid", cfg_if.o_cfg_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", cfg_if.o_cfg_valid, 0);
        chk("arst_state", state, 0);
        chk("arst_active", active, 0);
        step();
        rst_n = 1'b1;
        step();
        chk("sb_left", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
